// File: rtl/array_col_feeder.sv
// Column feeder between the three column FIFOs and the 3x3 MAC array: lockstep pops, 0/1/2-cycle skew.
// Optional FEEDER_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module array_col_feeder #(
    parameter int DATA_W = 32,
    parameter int TILE_K = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fifo_empty1,
    input  logic              fifo_empty2,
    input  logic              fifo_empty3,
    output logic              rd_en,
    input  logic [DATA_W-1:0] fifo_dout1,
    input  logic [DATA_W-1:0] fifo_dout2,
    input  logic [DATA_W-1:0] fifo_dout3,
    output logic [DATA_W-1:0] col_data1,
    output logic [DATA_W-1:0] col_data2,
    output logic [DATA_W-1:0] col_data3,
    output logic              col_valid1,
    output logic              col_valid2,
    output logic              col_valid3,
    output logic              busy,
    output logic              tile_done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [CNT_W-1:0] TILE_K_C = CNT_W'(TILE_K);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              all_ready;
    logic              pipe_empty;

    logic              rv;
    logic [DATA_W-1:0] c2_d;
    logic              c2_v;
    logic [DATA_W-1:0] c3_d0;
    logic              c3_v0;
    logic [DATA_W-1:0] c3_d1;
    logic              c3_v1;

    assign all_ready  = ~fifo_empty1 & ~fifo_empty2 & ~fifo_empty3;
    assign rd_en      = (state == RUN) & all_ready & (count < TILE_K_C);
    // Everything upstream of the column 3 output register has drained.
    assign pipe_empty = ~(rv | col_valid1 | c2_v | col_valid2 | c3_v0 | c3_v1);

    // Tile sequencing FSM with registered busy/tile_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= {CNT_W{1'b0}};
            busy      <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        count <= {CNT_W{1'b0}};
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (count == TILE_K_C) begin
                        state <= FLUSH;
                    end else if (rd_en) begin
                        count <= count + CNT_W'(1);
                    end
                end
                FLUSH: begin
                    if (pipe_empty) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        tile_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Skew pipeline; data registers load only with a valid word so outputs hold across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv         <= 1'b0;
            col_valid1 <= 1'b0;
            col_data1  <= {DATA_W{1'b0}};
            c2_v       <= 1'b0;
            c2_d       <= {DATA_W{1'b0}};
            col_valid2 <= 1'b0;
            col_data2  <= {DATA_W{1'b0}};
            c3_v0      <= 1'b0;
            c3_d0      <= {DATA_W{1'b0}};
            c3_v1      <= 1'b0;
            c3_d1      <= {DATA_W{1'b0}};
            col_valid3 <= 1'b0;
            col_data3  <= {DATA_W{1'b0}};
        end else begin
            rv         <= rd_en;
            col_valid1 <= rv;
            c2_v       <= rv;
            c3_v0      <= rv;
            col_valid2 <= c2_v;
            c3_v1      <= c3_v0;
            col_valid3 <= c3_v1;
            if (rv) begin
                col_data1 <= fifo_dout1;
                c2_d      <= fifo_dout2;
                c3_d0     <= fifo_dout3;
            end
            if (c2_v) begin
                col_data2 <= c2_d;
            end
            if (c3_v0) begin
                c3_d1 <= c3_d0;
            end
            if (c3_v1) begin
                col_data3 <= c3_d1;
            end
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    // Saturating count of RUN cycles lost to an empty FIFO; held after the tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= 16'h0000;
        end else if ((state == RUN) && (count < TILE_K_C) && !all_ready
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_array_col_feeder.sv
// Self-checking bench for array_col_feeder: queue-based FIFO model, directed and randomized tiles.
module tb_array_col_feeder;

    localparam int DW = 32;
    localparam int TK = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          fifo_empty1, fifo_empty2, fifo_empty3;
    logic          rd_en;
    logic [DW-1:0] fifo_dout1 = '0, fifo_dout2 = '0, fifo_dout3 = '0;
    logic [DW-1:0] col_data1, col_data2, col_data3;
    logic          col_valid1, col_valid2, col_valid3;
    logic          busy, tile_done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    array_col_feeder dut (
        .clk(clk), .rst(rst), .start(start),
        .fifo_empty1(fifo_empty1), .fifo_empty2(fifo_empty2), .fifo_empty3(fifo_empty3),
        .rd_en(rd_en),
        .fifo_dout1(fifo_dout1), .fifo_dout2(fifo_dout2), .fifo_dout3(fifo_dout3),
        .col_data1(col_data1), .col_data2(col_data2), .col_data3(col_data3),
        .col_valid1(col_valid1), .col_valid2(col_valid2), .col_valid3(col_valid3),
        .busy(busy), .tile_done(tile_done)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q1[$], q2[$], q3[$];

    // FIFO model: registered read data, one cycle after the pop strobe.
    always @(posedge clk) begin
        if (rd_en && q1.size() > 0 && q2.size() > 0 && q3.size() > 0) begin
            fifo_dout1 <= q1.pop_front();
            fifo_dout2 <= q2.pop_front();
            fifo_dout3 <= q3.pop_front();
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rand_stall = 1'b0;
    int stall_at = -1;
    int stall_rem = 0;
    bit f1, f2, f3;
    bit td_prev = 1'b0;
    logic [DW-1:0] pd1 = '0, pd2 = '0, pd3 = '0;
    int pop_cyc[$], v_cyc1[$], v_cyc2[$], v_cyc3[$], done_cyc[$];
    logic [DW-1:0] v_dat1[$], v_dat2[$], v_dat3[$];
    logic [DW-1:0] e1[$], e2[$], e3[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st);
        @(negedge clk);
        start = st;
        if (rand_stall) begin
            f1 = ($urandom_range(0, 3) == 0);
            f2 = ($urandom_range(0, 3) == 0);
            f3 = ($urandom_range(0, 3) == 0);
        end else begin
            f1 = 1'b0;
            f3 = 1'b0;
            f2 = (pop_cyc.size() == stall_at) && (stall_rem > 0);
            if (f2) stall_rem--;
        end
        fifo_empty1 = (q1.size() == 0) || f1;
        fifo_empty2 = (q2.size() == 0) || f2;
        fifo_empty3 = (q3.size() == 0) || f3;
        #1;
        cyc++;
        if (rd_en) pop_cyc.push_back(cyc);
        if (col_valid1) begin v_cyc1.push_back(cyc); v_dat1.push_back(col_data1); end
        else chk("hold1", col_data1, pd1);
        if (col_valid2) begin v_cyc2.push_back(cyc); v_dat2.push_back(col_data2); end
        else chk("hold2", col_data2, pd2);
        if (col_valid3) begin v_cyc3.push_back(cyc); v_dat3.push_back(col_data3); end
        else chk("hold3", col_data3, pd3);
        pd1 = col_data1; pd2 = col_data2; pd3 = col_data3;
        if (tile_done) done_cyc.push_back(cyc);
        chk("rd_en_while_empty", rd_en & (fifo_empty1 | fifo_empty2 | fifo_empty3), 0);
        chk("valid_in_idle", !busy && !tile_done && (col_valid1 | col_valid2 | col_valid3), 0);
        chk("rd_en_not_busy", rd_en && !busy, 0);
        chk("tile_done_width", tile_done && td_prev, 0);
        td_prev = tile_done;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tile_done"}, tile_done, 0);
        chk({tag, "_valids"}, {col_valid1, col_valid2, col_valid3}, 0);
        chk({tag, "_data1"}, col_data1, 0);
        chk({tag, "_data2"}, col_data2, 0);
        chk({tag, "_data3"}, col_data3, 0);
    endtask

    task automatic run_tile(input bit rnd, input int sat, input int slen,
                            input bit extra_starts, input int exp_lat);
        int s;
        int n;
        for (int i = 0; i < TK; i++) begin
            q1.push_back($urandom()); q2.push_back($urandom()); q3.push_back($urandom());
        end
        e1.delete(); e2.delete(); e3.delete();
        for (int i = 0; i < TK; i++) begin
            e1.push_back(q1[i]); e2.push_back(q2[i]); e3.push_back(q3[i]);
        end
        pop_cyc.delete(); done_cyc.delete();
        v_cyc1.delete(); v_cyc2.delete(); v_cyc3.delete();
        v_dat1.delete(); v_dat2.delete(); v_dat3.delete();
        rand_stall = rnd; stall_at = sat; stall_rem = slen;
        step(1'b1);
        s = cyc;
        step(1'b0);
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < TK * 4 + 40 && done_cyc.size() == 0; k++) begin
            step(extra_starts && ((cyc + 1 == s + 3) || (cyc + 1 == s + TK + 3)
                                  || (cyc + 1 == s + TK + 5)));
        end
        chk("tile_done_seen", done_cyc.size(), 1);
        rand_stall = 1'b0; stall_at = -1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0);
            chk("idle_after_tile", busy, 0);
        end
        chk("single_tile_done", done_cyc.size(), 1);
        chk("pop_count", pop_cyc.size(), TK);
        chk("valid_count1", v_cyc1.size(), TK);
        chk("valid_count2", v_cyc2.size(), TK);
        chk("valid_count3", v_cyc3.size(), TK);
        n = TK;
        if (pop_cyc.size() < n) n = pop_cyc.size();
        if (v_cyc1.size() < n) n = v_cyc1.size();
        if (v_cyc2.size() < n) n = v_cyc2.size();
        if (v_cyc3.size() < n) n = v_cyc3.size();
        for (int i = 0; i < n; i++) begin
            chk("col1_data", v_dat1[i], e1[i]);
            chk("col2_data", v_dat2[i], e2[i]);
            chk("col3_data", v_dat3[i], e3[i]);
            chk("col1_latency", v_cyc1[i], pop_cyc[i] + 2);
            chk("col2_skew", v_cyc2[i], v_cyc1[i] + 1);
            chk("col3_skew", v_cyc3[i], v_cyc1[i] + 2);
        end
        if (done_cyc.size() > 0 && v_cyc3.size() > 0)
            chk("done_after_col3", done_cyc[0], v_cyc3[v_cyc3.size() - 1] + 1);
        if (exp_lat >= 0 && done_cyc.size() > 0)
            chk("start_to_done", done_cyc[0] - s, exp_lat);
`ifdef FEEDER_STALL_CNT_EN
        if (pop_cyc.size() == TK)
            chk("stall_cnt", stall_cnt, pop_cyc[TK - 1] - s - TK);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        fifo_empty1 = 1'b1; fifo_empty2 = 1'b1; fifo_empty3 = 1'b1;
        step(1'b0);
        check_zero("reset");
        step(1'b0);
        rst = 1'b0;
        step(1'b0);

        // No stalls, with start re-pulsed in RUN, FLUSH and DONE.
        run_tile(1'b0, -1, 0, 1'b1, TK + 5);
        // Column 2 FIFO empty for three cycles after the second pop.
        run_tile(1'b0, 2, 3, 1'b0, TK + 8);

        // Reset two cycles into RUN, then a fresh tile from the next FIFO words.
        for (int i = 0; i < TK; i++) begin
            q1.push_back($urandom()); q2.push_back($urandom()); q3.push_back($urandom());
        end
        step(1'b1);
        step(1'b0);
        step(1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        pd1 = '0; pd2 = '0; pd3 = '0;
        step(1'b0);
        rst = 1'b0;
        step(1'b0);
        run_tile(1'b0, -1, 0, 1'b0, TK + 5);

        // Randomized FIFO-empty stalls.
        for (int r = 0; r < 4; r++) run_tile(1'b1, -1, 0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
